apb_mem_slave: RTL and testbench

APB_MEM_SLAVE -- requirements
Module: apb_mem_slave

---
 rtl/apb_slave_pkg.sv | 19 +
 rtl/apb_strb_ram.sv | 30 +++
 rtl/apb_mem_slave.sv | 131 +++++++++++++
 tb/tb_apb_mem_slave.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB memory slave.
// Holds the FSM encoding, lane-offset helper and wait-state limits.
package apb_slave_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int WAIT_STATES_MIN = 0;
    localparam int WAIT_STATES_MAX = 15;
    localparam int CNT_W           = 4;

    // Number of PADDR bits that select a byte within one data word.
    function automatic int lane_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/apb_strb_ram.sv
// Word-addressed RAM split into byte lanes with per-lane write enables.
// Asynchronous read, single-edge write; a write is visible to the next cycle's read.
module apb_strb_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int AW         = 8
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [AW-1:0]           idx,
    input  logic [DATA_WIDTH/8-1:0] strb,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int NB = DATA_WIDTH / 8;

    for (genvar g = 0; g < NB; g++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];

        always_ff @(posedge clk) begin
            if (we && strb[g]) begin
                lane_mem[idx] <= wdata[8*g +: 8];
            end
        end

        assign rdata[8*g +: 8] = lane_mem[idx];
    end

endmodule

// File: rtl/apb_mem_slave.sv
// APB slave in front of a byte-strobed word memory with a programmable wait count.
// PREADY is a decode of registered state only; errors and read data are captured at setup.
module apb_mem_slave
    import apb_slave_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 2,
    parameter int RO_WORDS    = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    output logic                    PREADY,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PSLVERR
);

    localparam int L      = lane_lsb(DATA_WIDTH);
    localparam int IDX_W  = ADDR_WIDTH - L;
    localparam int RAM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [IDX_W:0]   DEPTH_C = MEM_DEPTH[IDX_W:0];
    localparam logic [IDX_W:0]   RO_C    = RO_WORDS[IDX_W:0];
    localparam logic [CNT_W-1:0] WS_C    = WAIT_STATES[CNT_W-1:0];

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [RAM_AW-1:0]       idx_q, idx_d;
    logic                    write_q, write_d;

    logic [IDX_W-1:0]        paddr_idx;
    logic                    in_range;
    logic                    read_only;
    logic                    setup;
    logic                    access_en;
    logic                    ready_int;
    logic                    commit;
    logic [RAM_AW-1:0]       ram_idx;
    logic [DATA_WIDTH-1:0]   ram_rdata;

    assign paddr_idx = PADDR[ADDR_WIDTH-1:L];
    assign in_range  = {1'b0, paddr_idx} < DEPTH_C;
    assign read_only = {1'b0, paddr_idx} < RO_C;
    assign setup     = PSEL && !PENABLE;
    assign access_en = (state_q == ACCESS) && PSEL && PENABLE;
    assign ready_int = (state_q == ACCESS) && (cnt_q == WS_C);

    // The write uses the index latched at setup so a mid-transfer PADDR change
    // can never redirect it; reset in the completing cycle drops the write.
    assign commit  = access_en && ready_int && write_q && !err_q && !PRESET;
    assign ram_idx = commit ? idx_q : paddr_idx[RAM_AW-1:0];

    if (L > 0) begin : g_lsb_unused
        logic unused_lsb;
        assign unused_lsb = ^PADDR[L-1:0];
    end

    apb_strb_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_DEPTH),
        .AW         (RAM_AW)
    ) u_ram (
        .clk   (PCLK),
        .we    (commit),
        .idx   (ram_idx),
        .strb  (PSTRB),
        .wdata (PWDATA),
        .rdata (ram_rdata)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            idx_q   <= idx_d;
            write_q <= write_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        idx_d   = idx_q;
        write_d = write_q;
        if (setup) begin
            state_d = ACCESS;
            cnt_d   = '0;
            err_d   = !in_range || (PWRITE && read_only);
            rdata_d = (!PWRITE && in_range) ? ram_rdata : '0;
            idx_d   = paddr_idx[RAM_AW-1:0];
            write_d = PWRITE;
        end else if (state_q == ACCESS) begin
            if (!PSEL) begin
                state_d = IDLE;
            end else if (PENABLE) begin
                if (ready_int) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        PREADY  = ready_int;
        PSLVERR = err_q && ready_int;
        PRDATA  = (ready_int && !write_q && !err_q) ? rdata_q : '0;
    end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Randomized and directed bench for apb_mem_slave against a word/byte-mask memory model.
// Two instances: wait count 2 and wait count 0.
module tb_apb_mem_slave;

    localparam int DEPTH = 64;
    localparam int RO    = 4;

    logic        clk = 1'b0;
    logic        preset;
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [11:0] paddr   [2];
    logic [3:0]  pstrb   [2];
    logic [31:0] pwdata  [2];
    logic        pready  [2];
    logic [31:0] prdata  [2];
    logic        pslverr [2];

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl   [2][DEPTH];
    logic [3:0]  known [2][DEPTH];

    always #5 clk = ~clk;

    apb_mem_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH),
                    .WAIT_STATES(2), .RO_WORDS(RO)) dut (
        .PCLK(clk), .PRESET(preset), .PSEL(psel[0]), .PENABLE(penable[0]),
        .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PSTRB(pstrb[0]), .PWDATA(pwdata[0]),
        .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0]));

    apb_mem_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH),
                    .WAIT_STATES(0), .RO_WORDS(RO)) dut0 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel[1]), .PENABLE(penable[1]),
        .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PSTRB(pstrb[1]), .PWDATA(pwdata[1]),
        .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1]));

    function automatic int ws_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle(input int d);
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
    endtask

    // Called #1 after a rising edge; returns #1 after the completing edge.
    task automatic xfer(input int d, input bit wr, input logic [11:0] addr,
                        input logic [3:0] strb, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic er, output int cyc);
        bit done;
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
        paddr[d] = addr; pstrb[d] = strb; pwdata[d] = wdata;
        tick();
        penable[d] = 1'b1;
        cyc = 0; rd = '0; er = 1'b0; done = 1'b0;
        while (!done) begin
            cyc++;
            if (pready[d]) begin
                rd = prdata[d];
                er = pslverr[d];
                done = 1'b1;
            end else begin
                chk("wait_outputs", {31'd0, pslverr[d], prdata[d]}, 64'd0);
                if (cyc >= 20) begin
                    chk("ready_timeout", 64'(cyc), 64'(ws_of(d) + 1));
                    done = 1'b1;
                end
            end
            tick();
        end
    endtask

    task automatic check_xfer(input int d, input bit wr, input logic [11:0] addr,
                              input logic [3:0] strb, input logic [31:0] wdata,
                              input logic [31:0] rd, input logic er, input int cyc);
        int   idx;
        bit   exp_err;
        logic [31:0] m;
        idx = int'(addr[11:2]);
        exp_err = (idx >= DEPTH) || (wr && idx < RO);
        chk("latency", 64'(cyc), 64'(ws_of(d) + 1));
        chk("pslverr", {63'd0, er}, {63'd0, exp_err});
        if (wr || exp_err) begin
            chk("prdata_zero", {32'd0, rd}, 64'd0);
        end
        if (!exp_err) begin
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) mdl[d][idx][8*b +: 8] = wdata[8*b +: 8];
                known[d][idx] = known[d][idx] | strb;
            end else begin
                for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{known[d][idx][b]}};
                chk("rdata", {32'd0, rd & m}, {32'd0, mdl[d][idx] & m});
                mdl[d][idx]   = (mdl[d][idx] & m) | (rd & ~m);
                known[d][idx] = 4'hF;
            end
        end
    endtask

    task automatic do_xfer(input int d, input bit wr, input logic [11:0] addr,
                           input logic [3:0] strb, input logic [31:0] wdata,
                           output logic [31:0] rd);
        logic er;
        int   cyc;
        xfer(d, wr, addr, strb, wdata, rd, er, cyc);
        check_xfer(d, wr, addr, strb, wdata, rd, er, cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int gap;
        for (int d = 0; d < 2; d++) begin
            bus_idle(d);
            pwrite[d] = 1'b0; paddr[d] = '0; pstrb[d] = '0; pwdata[d] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                mdl[d][i]   = '0;
                known[d][i] = 4'h0;
            end
        end
        preset = 1'b1;
        repeat (3) tick();
        for (int d = 0; d < 2; d++)
            chk("reset_outputs", {31'd0, pready[d], pslverr[d], prdata[d]}, 64'd0);
        preset = 1'b0;
        tick();

        // Full write then read of word 16.
        do_xfer(0, 1'b1, 12'h040, 4'hF, 32'hDEADBEEF, rd);
        do_xfer(0, 1'b0, 12'h040, 4'h0, 32'h0, rd);
        chk("full_word", {32'd0, rd}, 64'hDEADBEEF);

        // Partial-lane merge.
        do_xfer(0, 1'b1, 12'h040, 4'hF, 32'h11223344, rd);
        do_xfer(0, 1'b1, 12'h040, 4'h5, 32'hAABBCCDD, rd);
        do_xfer(0, 1'b0, 12'h041, 4'h0, 32'h0, rd);
        chk("strobe_merge", {32'd0, rd}, 64'h11BB33DD);

        // Empty strobe completes cleanly and changes nothing.
        do_xfer(0, 1'b1, 12'h040, 4'h0, 32'h55555555, rd);
        do_xfer(0, 1'b0, 12'h040, 4'h0, 32'h0, rd);
        chk("zero_strobe", {32'd0, rd}, 64'h11BB33DD);

        // Out-of-range read and read-only write.
        do_xfer(0, 1'b0, 12'h100, 4'h0, 32'h0, rd);
        do_xfer(0, 1'b0, 12'h004, 4'h0, 32'h0, rd);
        do_xfer(0, 1'b1, 12'h004, 4'hF, 32'h12345678, rd);
        do_xfer(0, 1'b0, 12'h004, 4'h0, 32'h0, rd);
        bus_idle(0);
        tick();

        // Reset during the second access cycle of a write to word 0x20.
        do_xfer(0, 1'b1, 12'h080, 4'hF, 32'h5A5A1234, rd);
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
        paddr[0] = 12'h080; pstrb[0] = 4'hF; pwdata[0] = 32'hFFFFFFFF;
        tick();
        penable[0] = 1'b1;
        chk("rst_acc1_ready", {63'd0, pready[0]}, 64'd0);
        tick();
        chk("rst_acc2_ready", {63'd0, pready[0]}, 64'd0);
        preset = 1'b1;
        tick();
        chk("rst_outputs", {31'd0, pready[0], pslverr[0], prdata[0]}, 64'd0);
        preset = 1'b0;
        bus_idle(0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_no_ready", {63'd0, pready[0]}, 64'd0);
        end
        do_xfer(0, 1'b0, 12'h080, 4'h0, 32'h0, rd);
        chk("rst_word_kept", {32'd0, rd}, 64'h5A5A1234);

        // PSEL dropped on the first access cycle.
        do_xfer(0, 1'b1, 12'h084, 4'hF, 32'h01020304, rd);
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
        paddr[0] = 12'h084; pstrb[0] = 4'hF; pwdata[0] = 32'hCAFEF00D;
        tick();
        psel[0] = 1'b0; penable[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_ready", {63'd0, pready[0]}, 64'd0);
            tick();
        end
        bus_idle(0);
        do_xfer(0, 1'b0, 12'h084, 4'h0, 32'h0, rd);
        chk("abort_word_kept", {32'd0, rd}, 64'h01020304);

        // PENABLE high from idle without a setup cycle.
        do_xfer(0, 1'b1, 12'h088, 4'hF, 32'h0BADF00D, rd);
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
        paddr[0] = 12'h088; pstrb[0] = 4'hF; pwdata[0] = 32'hFFFF0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_setup_ready", {63'd0, pready[0]}, 64'd0);
        end
        bus_idle(0);
        tick();
        do_xfer(0, 1'b0, 12'h088, 4'h0, 32'h0, rd);
        chk("no_setup_word", {32'd0, rd}, 64'h0BADF00D);

        // Zero wait states: back-to-back write then read.
        do_xfer(1, 1'b1, 12'h0C0, 4'hF, 32'h13579BDF, rd);
        do_xfer(1, 1'b0, 12'h0C0, 4'h0, 32'h0, rd);
        chk("b2b_read", {32'd0, rd}, 64'h13579BDF);
        bus_idle(1);

        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < ((d == 0) ? 120 : 80); n++) begin
                do_xfer(d, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 12'h13F)),
                        4'($urandom_range(0, 15)), $urandom, rd);
                gap = $urandom_range(0, 2);
                if (gap > 0) begin
                    bus_idle(d);
                    repeat (gap) tick();
                end
            end
            bus_idle(d);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
